// File: rtl/wb_stage_param.sv
// wb_stage_param - writeback stage of the five-stage MIPS pipeline.
//
// Registers the M/W payload and aligns/extends load data.
// Selects the writeback value and owns the general register file (GRF).
// Provides bypassed read ports for decode and forwarding outputs for the
// hazard unit. It also counts retired instructions.
//
// Parameters:
//   REG_NUM   number of GPRs (power of two >= 2); AW = $clog2(REG_NUM)
//   ZERO_REG  1: register 0 reads as 0 and ignores writes
//
// Ports:
//   Clk, Rst          clock; synchronous active-low reset
//   In_Valid/Flush    M-stage instruction valid / discard it this cycle
//   In_PC             instruction PC
//   In_RegWe/RegAddr  GPR write enable / destination
//   In_Sel            0 ALU, 1 load, 2 PC+8, 3 zero
//   In_ALU, In_DM     ALU result, raw data-memory word
//   In_LdType         0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu (others as lw)
//   In_ByteOff        load address[1:0]
//   A1, A2 / RD1, RD2 read addresses / bypassed read data
//   Fwd_Valid/Addr/Data  pending W-stage GRF write
//   W_PC              PC of the W-stage instruction
//   Retired           count of retired valid instructions (wraps)
//
// Optional feature macro WB_HILO_EN:
//   Adds HI/LO registers with In_HiWe, In_LoWe, In_Hi, In_Lo, Out_Hi, Out_Lo.
module wb_stage_param #(
  parameter int REG_NUM  = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          In_Valid,
  input  logic          In_Flush,
  input  logic [31:0]   In_PC,
  input  logic          In_RegWe,
  input  logic [AW-1:0] In_RegAddr,
  input  logic [1:0]    In_Sel,
  input  logic [31:0]   In_ALU,
  input  logic [31:0]   In_DM,
  input  logic [2:0]    In_LdType,
  input  logic [1:0]    In_ByteOff,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic [31:0]   RD1,
  output logic [31:0]   RD2,
  output logic          Fwd_Valid,
  output logic [AW-1:0] Fwd_Addr,
  output logic [31:0]   Fwd_Data,
  output logic [31:0]   W_PC,
  output logic [31:0]   Retired
`ifdef WB_HILO_EN
  ,
  input  logic          In_HiWe,
  input  logic          In_LoWe,
  input  logic [31:0]   In_Hi,
  input  logic [31:0]   In_Lo,
  output logic [31:0]   Out_Hi,
  output logic [31:0]   Out_Lo
`endif
);

  // Align and extend a loaded word according to the load type.
  function automatic logic [31:0] load_ext(input logic [31:0] dm,
                                           input logic [2:0]  ld_type,
                                           input logic [1:0]  off);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    byte_v = 8'd0;
    half_v = 16'd0;
    res_v  = 32'd0;
    case (off)
      2'd0:    byte_v = dm[7:0];
      2'd1:    byte_v = dm[15:8];
      2'd2:    byte_v = dm[23:16];
      2'd3:    byte_v = dm[31:24];
      default: byte_v = dm[7:0];
    endcase
    // Halfword selection ignores the low offset bit.
    if (off[1]) begin
      half_v = dm[31:16];
    end else begin
      half_v = dm[15:0];
    end
    case (ld_type)
      3'd1:    res_v = {{24{byte_v[7]}}, byte_v};
      3'd2:    res_v = {24'd0, byte_v};
      3'd3:    res_v = {{16{half_v[15]}}, half_v};
      3'd4:    res_v = {16'd0, half_v};
      default: res_v = dm;
    endcase
    return res_v;
  endfunction

  logic          w_valid_r;
  logic [31:0]   w_pc_r;
  logic          w_regwe_r;
  logic [AW-1:0] w_addr_r;
  logic [1:0]    w_sel_r;
  logic [31:0]   w_alu_r;
  logic [31:0]   w_dm_r;
  logic [2:0]    w_ldtype_r;
  logic [1:0]    w_byteoff_r;
  logic [31:0]   retired_r;
  logic [31:0]   grf_r [REG_NUM];

  logic [31:0]   wd_s;
  logic          addr_is_zero_s;
  logic          write_en_s;
  logic [31:0]   rd1_s;
  logic [31:0]   rd2_s;

  // W pipeline register: captures every M/W field; a flush clears valid.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      w_valid_r   <= 1'b0;
      w_pc_r      <= 32'd0;
      w_regwe_r   <= 1'b0;
      w_addr_r    <= {AW{1'b0}};
      w_sel_r     <= 2'd0;
      w_alu_r     <= 32'd0;
      w_dm_r      <= 32'd0;
      w_ldtype_r  <= 3'd0;
      w_byteoff_r <= 2'd0;
    end else begin
      w_valid_r   <= In_Valid & ~In_Flush;
      w_pc_r      <= In_PC;
      w_regwe_r   <= In_RegWe;
      w_addr_r    <= In_RegAddr;
      w_sel_r     <= In_Sel;
      w_alu_r     <= In_ALU;
      w_dm_r      <= In_DM;
      w_ldtype_r  <= In_LdType;
      w_byteoff_r <= In_ByteOff;
    end
  end

  // Writeback value select and GRF write qualification.
  always_comb begin
    wd_s = 32'd0;
    case (w_sel_r)
      2'd0:    wd_s = w_alu_r;
      2'd1:    wd_s = load_ext(w_dm_r, w_ldtype_r, w_byteoff_r);
      2'd2:    wd_s = w_pc_r + 32'd8;
      default: wd_s = 32'd0;
    endcase
    addr_is_zero_s = (ZERO_REG != 0) && (w_addr_r == {AW{1'b0}});
    write_en_s     = w_valid_r & w_regwe_r & ~addr_is_zero_s;
  end

  // General register file; reset clears every entry and drops the pending write.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        grf_r[i] <= 32'd0;
      end
    end else begin
      if (write_en_s) begin
        grf_r[w_addr_r] <= wd_s;
      end
    end
  end

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      retired_r <= 32'd0;
    end else if (w_valid_r) begin
      retired_r <= retired_r + 32'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Read ports with write-through bypass of the pending W write.
  always_comb begin
    rd1_s = 32'd0;
    rd2_s = 32'd0;
    if ((ZERO_REG != 0) && (A1 == {AW{1'b0}})) begin
      rd1_s = 32'd0;
    end else if (write_en_s && (A1 == w_addr_r)) begin
      rd1_s = wd_s;
    end else begin
      rd1_s = grf_r[A1];
    end
    if ((ZERO_REG != 0) && (A2 == {AW{1'b0}})) begin
      rd2_s = 32'd0;
    end else if (write_en_s && (A2 == w_addr_r)) begin
      rd2_s = wd_s;
    end else begin
      rd2_s = grf_r[A2];
    end
  end

  assign RD1       = rd1_s;
  assign RD2       = rd2_s;
  assign Fwd_Valid = write_en_s;
  assign Fwd_Addr  = w_addr_r;
  assign Fwd_Data  = wd_s;
  assign W_PC      = w_pc_r;
  assign Retired   = retired_r;

`ifdef WB_HILO_EN
  logic        w_hiwe_r;
  logic        w_lowe_r;
  logic [31:0] w_hi_r;
  logic [31:0] w_lo_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        hi_we_s;
  logic        lo_we_s;

  // HI/LO payload carried alongside the W register.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      w_hiwe_r <= 1'b0;
      w_lowe_r <= 1'b0;
      w_hi_r   <= 32'd0;
      w_lo_r   <= 32'd0;
    end else begin
      w_hiwe_r <= In_HiWe;
      w_lowe_r <= In_LoWe;
      w_hi_r   <= In_Hi;
      w_lo_r   <= In_Lo;
    end
  end

  // HI/LO write qualification, gated by the W valid bit.
  always_comb begin
    hi_we_s = w_valid_r & w_hiwe_r;
    lo_we_s = w_valid_r & w_lowe_r;
  end

  // HI/LO architectural registers commit at the same edge as the GRF.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else begin
      if (hi_we_s) begin
        hi_r <= w_hi_r;
      end
      if (lo_we_s) begin
        lo_r <= w_lo_r;
      end
    end
  end

  assign Out_Hi = hi_we_s ? w_hi_r : hi_r;
  assign Out_Lo = lo_we_s ? w_lo_r : lo_r;
`endif

endmodule

// File: tb/tb_wb_stage_param.sv
module tb_wb_stage_param;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        In_Valid, In_Flush, In_RegWe;
  logic [31:0] In_PC, In_ALU, In_DM;
  logic [4:0]  In_RegAddr, A1, A2;
  logic [1:0]  In_Sel, In_ByteOff;
  logic [2:0]  In_LdType;
  logic [31:0] RD1, RD2, Fwd_Data, W_PC, Retired;
  logic        Fwd_Valid;
  logic [4:0]  Fwd_Addr;
`ifdef WB_HILO_EN
  logic        In_HiWe, In_LoWe;
  logic [31:0] In_Hi, In_Lo, Out_Hi, Out_Lo;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  wb_stage_param #(.REG_NUM(32), .ZERO_REG(1)) dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Flush(In_Flush),
    .In_PC(In_PC), .In_RegWe(In_RegWe), .In_RegAddr(In_RegAddr),
    .In_Sel(In_Sel), .In_ALU(In_ALU), .In_DM(In_DM),
    .In_LdType(In_LdType), .In_ByteOff(In_ByteOff), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .Fwd_Valid(Fwd_Valid), .Fwd_Addr(Fwd_Addr),
    .Fwd_Data(Fwd_Data), .W_PC(W_PC), .Retired(Retired)
`ifdef WB_HILO_EN
    , .In_HiWe(In_HiWe), .In_LoWe(In_LoWe), .In_Hi(In_Hi), .In_Lo(In_Lo),
    .Out_Hi(Out_Hi), .Out_Lo(Out_Lo)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_gpr [32];
  bit          m_v, m_we, chk_en = 1'b0;
  int unsigned m_addr;
  logic [31:0] m_data, m_pc, m_ret;

  function automatic logic [31:0] m_value(int unsigned sel, logic [31:0] alu,
                                          logic [31:0] dm, int unsigned lt,
                                          int unsigned off, logic [31:0] pc);
    logic [31:0] b, h;
    b = (dm >> (8 * off)) & 32'hFF;
    h = (dm >> (16 * (off / 2))) & 32'hFFFF;
    if (sel == 0) return alu;
    if (sel == 2) return pc + 32'd8;
    if (sel == 3) return 32'd0;
    case (lt)
      1: return (b >= 32'd128) ? b - 32'd256 : b;
      2: return b;
      3: return (h >= 32'd32768) ? h - 32'd65536 : h;
      4: return h;
      default: return dm;
    endcase
  endfunction

  function automatic logic [31:0] m_read(int unsigned a);
    if (a == 0) return 32'd0;
    if (m_v && m_we && m_addr != 0 && a == m_addr) return m_data;
    return m_gpr[a];
  endfunction

  // Model state advance at each rising edge.
  always @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_v = 0; m_we = 0; m_addr = 0; m_data = 32'd0; m_pc = 32'd0; m_ret = 32'd0;
      chk_en = 1'b1;
    end else begin
      if (m_v && m_we && m_addr != 0) m_gpr[m_addr] = m_data;
      if (m_v) m_ret = m_ret + 32'd1;
      m_v    = In_Valid && !In_Flush;
      m_we   = In_RegWe;
      m_addr = In_RegAddr;
      m_pc   = In_PC;
      m_data = m_value(In_Sel, In_ALU, In_DM, In_LdType, In_ByteOff, In_PC);
    end
  end

  // Compare process: every cycle once reset has been seen.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("RD1", RD1, m_read(A1));
      chk("RD2", RD2, m_read(A2));
      chk("Fwd_Valid", {31'd0, Fwd_Valid}, {31'd0, (m_v && m_we && m_addr != 0)});
      chk("Fwd_Addr", {27'd0, Fwd_Addr}, m_addr);
      chk("Fwd_Data", Fwd_Data, m_data);
      chk("W_PC", W_PC, m_pc);
      chk("Retired", Retired, m_ret);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    In_Valid = 0; In_Flush = 0; In_RegWe = 0; In_RegAddr = 5'd0; In_Sel = 2'd0;
    In_ALU = 32'd0; In_DM = 32'd0; In_LdType = 3'd0; In_ByteOff = 2'd0; In_PC = 32'd0;
`ifdef WB_HILO_EN
    In_HiWe = 0; In_LoWe = 0; In_Hi = 32'd0; In_Lo = 32'd0;
`endif
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present one instruction for a single accept edge, then go idle.
  task automatic issue(input bit fl, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [2:0] lt, input logic [1:0] off, input logic [31:0] pc);
    In_Valid = 1; In_Flush = fl; In_RegWe = 1; In_RegAddr = rd; In_Sel = sel;
    In_ALU = alu; In_DM = dm; In_LdType = lt; In_ByteOff = off; In_PC = pc;
    tick();
    idle_inputs();
  endtask

  initial begin
    Rst = 1'b0; A1 = 5'd5; A2 = 5'd0;
    idle_inputs();
    tick(); tick();
    @(negedge Clk);
    chk("rst_RD1", RD1, 32'd0);
    chk("rst_RD2", RD2, 32'd0);
    chk("rst_FwdV", {31'd0, Fwd_Valid}, 32'd0);
    chk("rst_FwdD", Fwd_Data, 32'd0);
    chk("rst_Ret", Retired, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b1;

    // ALU write with bypass, then committed value two cycles later.
    issue(0, 5'd5, 2'd0, 32'h12345678, 32'd0, 3'd0, 2'd0, 32'h100);
    A1 = 5'd5;
    @(negedge Clk);
    chk("byp_RD1", RD1, 32'h12345678);
    chk("byp_FwdV", {31'd0, Fwd_Valid}, 32'd1);
    tick(); tick();
    @(negedge Clk);
    chk("grf_RD1", RD1, 32'h12345678);
    chk("ret_1", Retired, 32'd1);
    tick();

    // Load extension cases.
    issue(0, 5'd6, 2'd1, 32'd0, 32'h80FF7F01, 3'd1, 2'd3, 32'h104);
    @(negedge Clk); chk("lb3", Fwd_Data, 32'hFFFFFF80); chk("m_lb3", m_data, 32'hFFFFFF80);
    issue(0, 5'd7, 2'd1, 32'd0, 32'h80FF7F01, 3'd2, 2'd3, 32'h108);
    @(negedge Clk); chk("lbu3", Fwd_Data, 32'h00000080); chk("m_lbu3", m_data, 32'h00000080);
    issue(0, 5'd8, 2'd1, 32'd0, 32'h80FF7F01, 3'd3, 2'd2, 32'h10C);
    @(negedge Clk); chk("lh2", Fwd_Data, 32'hFFFF80FF); chk("m_lh2", m_data, 32'hFFFF80FF);
    issue(0, 5'd9, 2'd1, 32'd0, 32'h80FF7F01, 3'd4, 2'd0, 32'h110);
    @(negedge Clk); chk("lhu0", Fwd_Data, 32'h00007F01); chk("m_lhu0", m_data, 32'h00007F01);

    // Write to $0 is suppressed.
    A1 = 5'd0;
    issue(0, 5'd0, 2'd0, 32'hDEADBEEF, 32'd0, 3'd0, 2'd0, 32'h114);
    @(negedge Clk);
    chk("z_FwdV", {31'd0, Fwd_Valid}, 32'd0);
    chk("z_RD1", RD1, 32'd0);

    // jal link value.
    A1 = 5'd31;
    issue(0, 5'd31, 2'd2, 32'd0, 32'd0, 3'd0, 2'd0, 32'h3000);
    @(negedge Clk);
    chk("jal_byp", RD1, 32'h00003008);

    // Flushed instruction changes nothing.
    A1 = 5'd5;
    issue(1, 5'd5, 2'd0, 32'hFFFFFFFF, 32'd0, 3'd0, 2'd0, 32'h118);
    @(negedge Clk);
    chk("fl_RD1", RD1, 32'h12345678);
    chk("fl_ret", Retired, 32'd7);
    tick();
    @(negedge Clk);
    chk("fl_ret2", Retired, 32'd7);
    A1 = 5'd31;
    #1 chk("jal_grf", RD1, 32'h00003008);

    // Reset while a write sits in W drops it.
    A1 = 5'd10;
    issue(0, 5'd10, 2'd0, 32'h00000055, 32'd0, 3'd0, 2'd0, 32'h11C);
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    @(negedge Clk);
    chk("rst_drop", RD1, 32'd0);

`ifdef WB_HILO_EN
    In_Valid = 1; In_HiWe = 1; In_Hi = 32'hA5A5A5A5;
    tick();
    idle_inputs();
    @(negedge Clk); chk("hi_byp", Out_Hi, 32'hA5A5A5A5);
    tick();
    @(negedge Clk); chk("hi_reg", Out_Hi, 32'hA5A5A5A5);
`endif

    // Randomised phase; a narrow address range makes bypass hits frequent.
    for (int n = 0; n < 3000; n++) begin
      Rst        = ($urandom_range(0, 99) != 0);
      In_Valid   = $urandom_range(0, 3) != 0;
      In_Flush   = $urandom_range(0, 7) == 0;
      In_RegWe   = $urandom_range(0, 3) != 0;
      In_RegAddr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      In_Sel     = 2'($urandom);
      In_ALU     = $urandom;
      In_DM      = $urandom;
      In_LdType  = 3'($urandom);
      In_ByteOff = 2'($urandom);
      In_PC      = $urandom;
      A1         = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      A2         = ($urandom_range(0, 3) == 0) ? A1 : 5'($urandom);
      tick();
    end
    Rst = 1'b1;
    idle_inputs();
    tick(); tick();
    @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
